// File: rtl/hs_ifr_misc_typedefs_pkg.sv
// Shared small typedefs for interrupt-front-end blocks: edge/level selectors and trigger mode.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package hs_ifr_misc_typedefs_pkg;

  // Edge(s) that fire an event in edge mode.
  typedef enum logic [1:0] {
    EDGE_POSEDGE = 2'd0,
    EDGE_NEGEDGE = 2'd1,
    EDGE_BOTH    = 2'd2
  } edge_e;

  // Active level in level mode; LEVEL_BOTH is meaningless for a single bit level match.
  typedef enum logic [1:0] {
    LEVEL_LOW  = 2'd0,
    LEVEL_HIGH = 2'd1,
    LEVEL_BOTH = 2'd2
  } level_e;

  // Trigger style of an event detector.
  typedef enum logic {
    TRIG_EDGE  = 1'b0,
    TRIG_LEVEL = 1'b1
  } trig_mode_e;

  // Legal parameter ranges shared by the detector and its synchronizer.
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEBOUNCE_MAX    = 65535;
  localparam int DEB_CNT_W       = 16;

  // True when the transition prev -> cur is one of the selected edges.
  function automatic logic edge_hit(input logic prev, input logic cur, input edge_e sel);
    logic hit;
    hit = 1'b0;
    case (sel)
      EDGE_POSEDGE: hit = ~prev & cur;
      EDGE_NEGEDGE: hit = prev & ~cur;
      EDGE_BOTH:    hit = prev ^ cur;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/hs_ifr_bit_sync.sv
// Single-bit multi-flop synchronizer bringing an asynchronous input into the clk domain.
// Latency: STAGES clk cycles from the first sampling edge to q.
// Backpressure: none; the input is sampled every cycle.
module hs_ifr_bit_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // A single flop gives no metastability protection, so refuse to build one.
  if (STAGES < 2) begin : g_bad_stages
    $error("hs_ifr_bit_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain; the oldest stage is the clean output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/hs_ifr_evt_detect.sv
// Interrupt event detector: synchronize, debounce, then edge/level detect into a strobe plus sticky pend/ovf flags.
// Latency: edge event strobe appears SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after sig_i is first sampled.
// Backpressure: none; events are never stalled, pend_o records them and ovf_o flags a pending one being overrun.
module hs_ifr_evt_detect
  import hs_ifr_misc_typedefs_pkg::*;
#(
  parameter int         SYNC_STAGES     = 2,
  parameter int         DEBOUNCE_CYCLES = 0,
  parameter trig_mode_e TRIG_MODE       = TRIG_EDGE,
  parameter edge_e      EDGE_SEL        = EDGE_POSEDGE,
  parameter level_e     LEVEL_SEL       = LEVEL_HIGH,
  parameter bit         INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sig_i,
  input  logic clr_i,
  output logic sig_filt_o,
  output logic evt_pulse_o,
  output logic pend_o,
  output logic ovf_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("hs_ifr_evt_detect: SYNC_STAGES out of range 2..4");
  end

  if (DEBOUNCE_CYCLES < 0 || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_deb
    $error("hs_ifr_evt_detect: DEBOUNCE_CYCLES out of range 0..65535");
  end

  if (TRIG_MODE == TRIG_LEVEL && LEVEL_SEL == LEVEL_BOTH) begin : g_bad_level
    $error("hs_ifr_evt_detect: LEVEL_BOTH is not a valid level in level mode");
  end

  // Level that counts as active in level mode (LEVEL_BOTH is excluded above).
  localparam logic ACTIVE_LVL = (LEVEL_SEL == LEVEL_HIGH);

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic s;

  hs_ifr_bit_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (INIT_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig_i),
    .q   (s)
  );

  // ---------------------------------------------------------------------------
  // Debounce filter
  // ---------------------------------------------------------------------------
  logic filt;

  if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
    // Filter bypassed: the synchronized signal is used as-is.
    assign filt = s;
  end else begin : g_deb
    // Counter value on the last disagreeing cycle before filt is allowed to follow s.
    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DEB_CNT_W-1:0] cnt;
    logic                 filt_q;

    // Count consecutive cycles where s disagrees with filt; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        filt_q <= INIT_LEVEL;
      end else if (s == filt_q) begin
        cnt    <= '0;
      end else if (cnt == CNT_LAST) begin
        filt_q <= s;
        cnt    <= '0;
      end else begin
        cnt    <= cnt + 1'b1;
      end
    end

    assign filt = filt_q;

    // The count never needs to go past the load point.
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= CNT_LAST);
  end

  assign sig_filt_o = filt;

  // ---------------------------------------------------------------------------
  // Event detection
  // ---------------------------------------------------------------------------
  logic prev;
  logic evt_cond;
  logic evt_q;
  logic pend_q;
  logic ovf_q;

  // Event condition from the filtered signal; independent of en so that prev keeps tracking.
  always_comb begin
    evt_cond = 1'b0;
    if (TRIG_MODE == TRIG_LEVEL) begin
      evt_cond = (filt == ACTIVE_LVL);
    end else begin
      evt_cond = edge_hit(prev, filt, EDGE_SEL);
    end
  end

  // prev follows filt every cycle, so enabling detection later sees no stale edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= INIT_LEVEL;
    end else begin
      prev <= filt;
    end
  end

  // Registered strobe, gated by the enable of the cycle in which the condition held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= en & evt_cond;
    end
  end

  // Sticky flags: a strobe sets pend, a strobe on an already-pending event sets ovf; set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= evt_q | (pend_q & ~clr_i);
      ovf_q  <= (evt_q & pend_q & ~clr_i) | (ovf_q & ~clr_i);
    end
  end

  assign evt_pulse_o = evt_q;
  assign pend_o      = pend_q;
  assign ovf_o       = ovf_q;

  // Overflow can only be recorded on top of a pending event, and both clear together.
  a_ovf_implies_pend: assert property (@(posedge clk) disable iff (rst) ovf_q |-> pend_q);

endmodule
